// File: rtl/mp64_uart_txdma_pkg.sv
// rtl/mp64_uart_txdma_pkg.sv - CSR map, UART offsets, control bits and FSM encodings for the console TX streamer
package mp64_uart_txdma_pkg;

    // CSR byte offsets within the block
    localparam logic [3:0] TXDMA_SRC0 = 4'h0;
    localparam logic [3:0] TXDMA_SRC1 = 4'h1;
    localparam logic [3:0] TXDMA_SRC2 = 4'h2;
    localparam logic [3:0] TXDMA_SRC3 = 4'h3;
    localparam logic [3:0] TXDMA_LEN0 = 4'h4;
    localparam logic [3:0] TXDMA_LEN1 = 4'h5;
    localparam logic [3:0] TXDMA_CTRL = 4'h6;
    localparam logic [3:0] TXDMA_STAT = 4'h7;

    // CTRL / STAT bit indices
    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    // UART MMIO offsets
    localparam logic [3:0] UART_TX     = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h1;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_POLL  = 3'd2;
    localparam logic [2:0] ST_PWAIT = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_WWAIT = 3'd5;

    // Little-endian byte lane select out of a 64-bit memory word
    function automatic logic [7:0] byte_lane(input logic [63:0] word, input logic [2:0] sel);
        return word[8*sel +: 8];
    endfunction

endpackage

// File: rtl/mp64_uart_txdma.sv
// rtl/mp64_uart_txdma.sv - DMA streamer feeding bytes from memory into the UART TX MMIO port
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   csr_req/addr/wdata/wen          CPU MMIO access (one-cycle pulse)
//   csr_rdata/csr_ack               registered response, one cycle after csr_req
//   mem_req/mem_addr                64-bit aligned word read, held until mem_ack
//   mem_rdata/mem_ack               read data and completion pulse
//   u_req/u_addr/u_wdata/u_wen      UART MMIO request (STATUS poll or TX write)
//   u_rdata/u_ack                   UART response, one cycle after u_req
//   irq                             level: done & irq_en
module mp64_uart_txdma
    import mp64_uart_txdma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_req,
    input  logic [3:0]        csr_addr,
    input  logic [7:0]        csr_wdata,
    input  logic              csr_wen,
    output logic [7:0]        csr_rdata,
    output logic              csr_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              u_req,
    output logic [3:0]        u_addr,
    output logic [7:0]        u_wdata,
    output logic              u_wen,
    input  logic [7:0]        u_rdata,
    input  logic              u_ack,
    output logic              irq
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [63:0]       word_q, word_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              abort_pend_q, abort_pend_d;
    logic              ack_q;
    logic [7:0]        rdata_q, rdata_d;

    logic              busy;
    logic              csr_wr;
    logic              wr_ctrl;
    logic              abort_now;

    // Only STATUS bit0 (tx_ready) matters
    logic unused_ok;
    assign unused_ok = ^u_rdata[7:1];

    assign busy    = (state_q != ST_IDLE);
    assign csr_wr  = csr_req & csr_wen;
    assign wr_ctrl = csr_wr & (csr_addr == TXDMA_CTRL);
    // An ABORT written in the same cycle a transaction completes still takes effect
    assign abort_now = abort_pend_q | (wr_ctrl & csr_wdata[CTRL_ABORT] & busy);

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        ptr_d        = ptr_q;
        len_d        = len_q;
        word_d       = word_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_now;

        // Address/count registers are frozen while a transfer runs
        if (csr_wr && !busy) begin
            case (csr_addr)
                TXDMA_SRC0: src_d[7:0]   = csr_wdata;
                TXDMA_SRC1: src_d[15:8]  = csr_wdata;
                TXDMA_SRC2: src_d[23:16] = csr_wdata;
                TXDMA_SRC3: src_d[31:24] = csr_wdata;
                TXDMA_LEN0: len_d[7:0]   = csr_wdata;
                TXDMA_LEN1: len_d[15:8]  = csr_wdata;
                default: ;
            endcase
        end

        if (wr_ctrl) begin
            irq_en_d = csr_wdata[CTRL_IRQ_EN];
        end

        // Software clears come first so a same-cycle hardware set wins
        if (csr_wr && csr_addr == TXDMA_STAT) begin
            if (csr_wdata[STAT_DONE])    done_d    = 1'b0;
            if (csr_wdata[STAT_ABORTED]) aborted_d = 1'b0;
        end

        if (wr_ctrl && csr_wdata[CTRL_START] && !busy) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
            if (len_q == '0) begin
                done_d = 1'b1;
            end else begin
                ptr_d   = src_q;
                state_d = ST_FETCH;
            end
        end

        case (state_q)
            ST_FETCH: begin
                if (mem_ack) begin
                    word_d = mem_rdata;
                    if (abort_now) begin
                        state_d      = ST_IDLE;
                        aborted_d    = 1'b1;
                        abort_pend_d = 1'b0;
                    end else begin
                        state_d = ST_POLL;
                    end
                end
            end
            ST_POLL:  state_d = ST_PWAIT;
            ST_PWAIT: begin
                if (u_ack) begin
                    if (abort_now) begin
                        state_d      = ST_IDLE;
                        aborted_d    = 1'b1;
                        abort_pend_d = 1'b0;
                    end else if (u_rdata[0]) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_POLL;
                    end
                end
            end
            ST_WRITE: state_d = ST_WWAIT;
            ST_WWAIT: begin
                if (u_ack) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    len_d = len_q - LEN_W'(1);
                    // The last byte going out means the transfer completed, abort or not
                    if (len_q == LEN_W'(1)) begin
                        state_d      = ST_IDLE;
                        done_d       = 1'b1;
                        abort_pend_d = 1'b0;
                    end else if (abort_now) begin
                        state_d      = ST_IDLE;
                        aborted_d    = 1'b1;
                        abort_pend_d = 1'b0;
                    end else if (ptr_d[2:0] == 3'd0) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_POLL;
                    end
                end
            end
            default: abort_pend_d = 1'b0;
        endcase
    end

    always_comb begin
        rdata_d = 8'h00;
        if (csr_req && !csr_wen) begin
            case (csr_addr)
                TXDMA_SRC0: rdata_d = src_q[7:0];
                TXDMA_SRC1: rdata_d = src_q[15:8];
                TXDMA_SRC2: rdata_d = src_q[23:16];
                TXDMA_SRC3: rdata_d = src_q[31:24];
                TXDMA_LEN0: rdata_d = len_q[7:0];
                TXDMA_LEN1: rdata_d = len_q[15:8];
                TXDMA_CTRL: rdata_d = {5'b0, irq_en_q, 2'b00};
                TXDMA_STAT: rdata_d = {5'b0, aborted_q, done_q, busy};
                default:    rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            src_q        <= '0;
            ptr_q        <= '0;
            len_q        <= '0;
            word_q       <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            ack_q        <= 1'b0;
            rdata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            word_q       <= word_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            ack_q        <= csr_req;
            rdata_q      <= rdata_d;
        end
    end

    assign csr_ack   = ack_q;
    assign csr_rdata = rdata_q;
    assign irq       = done_q & irq_en_q;

    // Bus outputs decode straight from the state register; idle drives zeros
    assign mem_req  = (state_q == ST_FETCH);
    assign mem_addr = (state_q == ST_FETCH) ? {ptr_q[ADDR_W-1:3], 3'b000} : '0;
    assign u_req    = (state_q == ST_POLL) || (state_q == ST_WRITE);
    assign u_wen    = (state_q == ST_WRITE);
    assign u_addr   = (state_q == ST_POLL)  ? UART_STATUS :
                      (state_q == ST_WRITE) ? UART_TX     : 4'h0;
    assign u_wdata  = (state_q == ST_WRITE) ? byte_lane(word_q, ptr_q[2:0]) : 8'h00;

endmodule
